// File: rtl/sn_adapter_axis_pkg.sv
// Shared definitions for the snooper-to-packet-memory AXI-Stream adapter:
// FSM state encoding and the byte-increment width helper.
package sn_adapter_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    // Bits needed to hold a byte count of 0..DATA_WIDTH/8 inclusive.
    function automatic int inc_width(input int data_width);
        return $clog2(data_width / 8) + 1;
    endfunction

endpackage

// File: rtl/sn_adapter_axis_keep_popcount.sv
// Combinational byte counter: number of set TKEEP bits in one stream beat.
module keep_popcount #(
    parameter  int KEEP_WIDTH = 8,
    localparam int CNT_WIDTH  = $clog2(KEEP_WIDTH) + 1
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + CNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/sn_adapter_axis.sv
// Writes AXI-Stream packets from the snooper word-by-word into the ping-pong
// packet memory, with truncation of oversize packets and a no-buffer policy.
module sn_adapter_axis
    import sn_adapter_axis_pkg::*;
#(
    parameter  int DATA_WIDTH   = 64,
    parameter  int ADDR_WIDTH   = 9,
    parameter  bit BACKPRESSURE = 1'b1,
    parameter  int CNT_WIDTH    = 16,
    localparam int INC_WIDTH    = inc_width(DATA_WIDTH),
    localparam int KEEP_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sn_TDATA,
    input  logic [KEEP_WIDTH-1:0] sn_TKEEP,
    input  logic                  sn_TLAST,
    input  logic                  sn_TVALID,
    output logic                  sn_TREADY,
    input  logic                  rdy_for_sn,
    output logic                  rdy_for_sn_ack,
    output logic [ADDR_WIDTH-1:0] sn_addr,
    output logic [DATA_WIDTH-1:0] sn_wr_data,
    output logic                  sn_wr_en,
    output logic [INC_WIDTH-1:0]  sn_byte_inc,
    output logic                  sn_done,
    output logic                  sn_trunc,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [INC_WIDTH-1:0]  keep_cnt;
    logic                  done_p1, trunc_p1;
    logic                  beat, keep_any, at_end;
    logic                  claim, write, finish, drop;

    keep_popcount #(.KEEP_WIDTH(KEEP_WIDTH)) u_popcount (
        .keep  (sn_TKEEP),
        .count (keep_cnt)
    );

    assign beat     = sn_TVALID && sn_TREADY;
    assign keep_any = |sn_TKEEP;
    assign at_end   = (word_addr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // A claim is held off while a done is still in flight so ack and done never overlap.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rdy_for_sn && !done_p1)
                    state_next = ST_WRITE;
                else if (beat && !sn_TLAST)
                    state_next = ST_DROP;
            end
            ST_WRITE: begin
                if (beat && sn_TLAST)
                    state_next = ST_IDLE;
                else if (beat && keep_any && at_end)
                    state_next = ST_TAIL;
            end
            ST_TAIL, ST_DROP: begin
                if (beat && sn_TLAST)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sn_TREADY = 1'b1;
        claim     = 1'b0;
        write     = 1'b0;
        finish    = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                sn_TREADY = !BACKPRESSURE && !rdy_for_sn;
                claim     = rdy_for_sn && !done_p1;
                drop      = beat;
            end
            ST_WRITE: begin
                write  = beat && keep_any;
                finish = beat && sn_TLAST;
            end
            ST_TAIL:  finish = beat && sn_TLAST;
            default:  ;
        endcase
    end

    // Stage p1: write beat registered; done is staged once more so it lands
    // the cycle after the final write strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_for_sn_ack <= 1'b0;
            sn_wr_en       <= 1'b0;
            sn_addr        <= '0;
            sn_wr_data     <= '0;
            sn_byte_inc    <= '0;
            sn_done        <= 1'b0;
            sn_trunc       <= 1'b0;
            done_p1        <= 1'b0;
            trunc_p1       <= 1'b0;
            word_addr      <= '0;
            drop_cnt       <= '0;
        end else begin
            rdy_for_sn_ack <= claim;
            sn_wr_en       <= write;
            if (write) begin
                sn_addr     <= word_addr;
                sn_wr_data  <= sn_TDATA;
                sn_byte_inc <= keep_cnt;
            end
            if (claim)
                word_addr <= '0;
            else if (write)
                word_addr <= word_addr + 1'b1;
            done_p1  <= finish;
            trunc_p1 <= finish && (state == ST_TAIL);
            sn_done  <= done_p1;
            sn_trunc <= done_p1 && trunc_p1;
            if (drop && (drop_cnt != {CNT_WIDTH{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sn_adapter_axis.sv
// Directed bench for sn_adapter_axis: default build (a), 4-word buffer (b),
// and drop policy with a 2-bit drop counter (c).
module tb_sn_adapter_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid_a = 1'b0, tvalid_b = 1'b0, tvalid_c = 1'b0;
    logic        rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;

    logic        tready_a, ack_a, wr_en_a, done_a, trunc_a;
    logic [8:0]  addr_a;
    logic [63:0] wr_data_a;
    logic [3:0]  inc_a;
    logic [15:0] drop_cnt_a;

    logic        tready_b, ack_b, wr_en_b, done_b, trunc_b;
    logic [1:0]  addr_b;
    logic [63:0] wr_data_b;
    logic [3:0]  inc_b;
    logic [15:0] drop_cnt_b;

    logic        tready_c, ack_c, wr_en_c, done_c, trunc_c;
    logic [8:0]  addr_c;
    logic [63:0] wr_data_c;
    logic [3:0]  inc_c;
    logic [1:0]  drop_cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sn_adapter_axis u_dut_a (
        .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TLAST(tlast),
        .sn_TVALID(tvalid_a), .sn_TREADY(tready_a), .rdy_for_sn(rdy_a),
        .rdy_for_sn_ack(ack_a), .sn_addr(addr_a), .sn_wr_data(wr_data_a),
        .sn_wr_en(wr_en_a), .sn_byte_inc(inc_a), .sn_done(done_a),
        .sn_trunc(trunc_a), .drop_cnt(drop_cnt_a)
    );

    sn_adapter_axis #(.ADDR_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TLAST(tlast),
        .sn_TVALID(tvalid_b), .sn_TREADY(tready_b), .rdy_for_sn(rdy_b),
        .rdy_for_sn_ack(ack_b), .sn_addr(addr_b), .sn_wr_data(wr_data_b),
        .sn_wr_en(wr_en_b), .sn_byte_inc(inc_b), .sn_done(done_b),
        .sn_trunc(trunc_b), .drop_cnt(drop_cnt_b)
    );

    sn_adapter_axis #(.BACKPRESSURE(1'b0), .CNT_WIDTH(2)) u_dut_c (
        .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TLAST(tlast),
        .sn_TVALID(tvalid_c), .sn_TREADY(tready_c), .rdy_for_sn(rdy_c),
        .rdy_for_sn_ack(ack_c), .sn_addr(addr_c), .sn_wr_data(wr_data_c),
        .sn_wr_en(wr_en_c), .sn_byte_inc(inc_c), .sn_done(done_c),
        .sn_trunc(trunc_c), .drop_cnt(drop_cnt_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        tdata = d;
        tkeep = k;
        tlast = l;
    endtask

    initial begin
        // Reset held with valid asserted
        rst = 1'b0;
        tvalid_a = 1'b1; tvalid_b = 1'b1; tvalid_c = 1'b1;
        set_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
        repeat (3) step();
        chk("rst_tready", 64'(tready_a), 64'(0));
        chk("rst_wr_en",  64'(wr_en_a),  64'(0));
        chk("rst_ack",    64'(ack_a),    64'(0));
        chk("rst_done",   64'(done_a),   64'(0));
        chk("rst_trunc",  64'(trunc_a),  64'(0));
        chk("rst_addr",   64'(addr_a),   64'(0));
        chk("rst_data",   wr_data_a,     64'(0));
        chk("rst_inc",    64'(inc_a),    64'(0));
        chk("rst_drop_a", 64'(drop_cnt_a), 64'(0));
        chk("rst_drop_c", 64'(drop_cnt_c), 64'(0));
        chk("rst_tready_b", 64'(tready_b), 64'(0));
        tvalid_a = 1'b0; tvalid_b = 1'b0; tvalid_c = 1'b0;
        rst = 1'b1;
        step();

        // Three-beat packet, keep FF,FF,0F
        rdy_a = 1'b1;
        step();
        chk("p2_ack", 64'(ack_a), 64'(1));
        rdy_a = 1'b0;
        tvalid_a = 1'b1;
        set_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        chk("p2_tready", 64'(tready_a), 64'(1));
        step();
        chk("p2_ack_off", 64'(ack_a), 64'(0));
        chk("p2_w0_en",   64'(wr_en_a), 64'(1));
        chk("p2_w0_addr", 64'(addr_a),  64'(0));
        chk("p2_w0_inc",  64'(inc_a),   64'(8));
        chk("p2_w0_data", wr_data_a,    64'h1111_1111_1111_1111);
        set_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        step();
        chk("p2_w1_addr", 64'(addr_a),  64'(1));
        chk("p2_w1_inc",  64'(inc_a),   64'(8));
        set_beat(64'h0000_0000_3333_3333, 8'h0F, 1'b1);
        step();
        chk("p2_w2_en",   64'(wr_en_a), 64'(1));
        chk("p2_w2_addr", 64'(addr_a),  64'(2));
        chk("p2_w2_inc",  64'(inc_a),   64'(4));
        chk("p2_w2_data", wr_data_a,    64'h0000_0000_3333_3333);
        chk("p2_w2_done", 64'(done_a),  64'(0));
        tvalid_a = 1'b0;
        step();
        chk("p2_done",     64'(done_a),  64'(1));
        chk("p2_trunc",    64'(trunc_a), 64'(0));
        chk("p2_done_wen", 64'(wr_en_a), 64'(0));
        step();
        chk("p2_done_off", 64'(done_a),  64'(0));

        // Backpressure with no free buffer
        tvalid_a = 1'b1;
        set_beat(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("p4_stall_tready", 64'(tready_a), 64'(0));
            step();
            chk("p4_stall_wen", 64'(wr_en_a), 64'(0));
        end
        rdy_a = 1'b1;
        step();
        chk("p4_ack", 64'(ack_a), 64'(1));
        chk("p4_no_wen", 64'(wr_en_a), 64'(0));
        rdy_a = 1'b0;
        chk("p4_tready", 64'(tready_a), 64'(1));
        step();
        chk("p4_w0_en",   64'(wr_en_a), 64'(1));
        chk("p4_w0_addr", 64'(addr_a),  64'(0));
        chk("p4_w0_data", wr_data_a,    64'hAAAA_0000_0000_0001);
        set_beat(64'h0000_0000_0000_BBBB, 8'h03, 1'b1);
        step();
        chk("p4_w1_addr", 64'(addr_a), 64'(1));
        chk("p4_w1_inc",  64'(inc_a),  64'(2));
        tvalid_a = 1'b0;
        step();
        chk("p4_done",  64'(done_a),  64'(1));
        chk("p4_trunc", 64'(trunc_a), 64'(0));
        step();

        // Four-word buffer: six-beat packet truncates
        rdy_b = 1'b1;
        step();
        chk("p3_ack", 64'(ack_b), 64'(1));
        rdy_b = 1'b0;
        tvalid_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_beat(64'(i + 16), 8'hFF, (i == 5));
            chk("p3_tready", 64'(tready_b), 64'(1));
            step();
            chk("p3_wen", 64'(wr_en_b), (i < 4) ? 64'(1) : 64'(0));
            if (i < 4) chk("p3_addr", 64'(addr_b), 64'(i));
            chk("p3_done_early", 64'(done_b), 64'(0));
        end
        tvalid_b = 1'b0;
        step();
        chk("p3_done",  64'(done_b),  64'(1));
        chk("p3_trunc", 64'(trunc_b), 64'(1));
        step();
        chk("p3_done_off",  64'(done_b),  64'(0));
        chk("p3_trunc_off", 64'(trunc_b), 64'(0));

        // Four-word buffer: exact-fit packet completes normally
        rdy_b = 1'b1;
        step();
        chk("p3b_ack", 64'(ack_b), 64'(1));
        rdy_b = 1'b0;
        tvalid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(64'(i + 32), 8'hFF, (i == 3));
            step();
            chk("p3b_wen",  64'(wr_en_b), 64'(1));
            chk("p3b_addr", 64'(addr_b),  64'(i));
        end
        tvalid_b = 1'b0;
        step();
        chk("p3b_done",  64'(done_b),  64'(1));
        chk("p3b_trunc", 64'(trunc_b), 64'(0));
        step();

        // Drop policy: two 4-beat packets, then three single-beat packets
        rdy_c = 1'b0;
        tvalid_c = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                set_beat(64'(i + 64), 8'hFF, (i == 3));
                chk("p5_tready", 64'(tready_c), 64'(1));
                step();
                chk("p5_wen",  64'(wr_en_c), 64'(0));
                chk("p5_done", 64'(done_c),  64'(0));
            end
            chk("p5_drop_cnt", 64'(drop_cnt_c), 64'(p + 1));
        end
        for (int p = 0; p < 3; p++) begin
            set_beat(64'(p + 80), 8'hFF, 1'b1);
            chk("p5_tready_1b", 64'(tready_c), 64'(1));
            step();
            chk("p5_drop_sat", 64'(drop_cnt_c), 64'(3));
        end
        tvalid_c = 1'b0;
        step();
        chk("p5_no_done", 64'(done_c), 64'(0));
        chk("p5_no_ack",  64'(ack_c),  64'(0));

        // Reset in the middle of a packet
        rdy_a = 1'b1;
        step();
        chk("p6_ack", 64'(ack_a), 64'(1));
        rdy_a = 1'b0;
        tvalid_a = 1'b1;
        set_beat(64'h6666_0000_0000_0000, 8'hFF, 1'b0);
        step();
        step();
        chk("p6_mid_addr", 64'(addr_a), 64'(1));
        rst = 1'b0;
        step();
        chk("p6_rst_wen",    64'(wr_en_a),  64'(0));
        chk("p6_rst_addr",   64'(addr_a),   64'(0));
        chk("p6_rst_done",   64'(done_a),   64'(0));
        chk("p6_rst_tready", 64'(tready_a), 64'(0));
        chk("p6_rst_drop_c", 64'(drop_cnt_c), 64'(0));
        rst = 1'b1;
        tvalid_a = 1'b0;
        rdy_a = 1'b1;
        step();
        chk("p6_re_ack", 64'(ack_a), 64'(1));
        rdy_a = 1'b0;
        tvalid_a = 1'b1;
        set_beat(64'h0000_0000_0000_0077, 8'h01, 1'b1);
        step();
        chk("p6_re_wen",  64'(wr_en_a), 64'(1));
        chk("p6_re_addr", 64'(addr_a),  64'(0));
        chk("p6_re_inc",  64'(inc_a),   64'(1));
        tvalid_a = 1'b0;
        step();
        chk("p6_re_done",  64'(done_a),  64'(1));
        chk("p6_re_trunc", 64'(trunc_a), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
